// File: rtl/cache_req_arb_if.sv
// Request-stage bundle between the cores, the round-robin arbiter and the cache.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface cache_req_arb_if #(
    parameter int NUM_CORES = 4,
    parameter int REQ_W     = 64,
    parameter int DEPTH     = 4
);
    localparam int ID_W  = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CORES-1:0][REQ_W-1:0] core_req;
    logic [NUM_CORES-1:0]            core_valid;
    logic [NUM_CORES-1:0]            core_ready;
    logic [REQ_W-1:0]                out_req;
    logic [ID_W-1:0]                 out_id;
    logic                            out_valid;
    logic                            out_ready;
    logic [CNT_W-1:0]                count;

    modport master (
        output core_req, core_valid, out_ready,
        input  core_ready, out_req, out_id, out_valid, count
    );

    modport slave (
        input  core_req, core_valid, out_ready,
        output core_ready, out_req, out_id, out_valid, count
    );
endinterface

// File: rtl/cache_req_arb.sv
// Round-robin arbiter over NUM_CORES request ports feeding a DEPTH-entry
// first-word-fall-through FIFO whose head drives the cache request input.
module cache_req_arb #(
    parameter int NUM_CORES = 4,
    parameter int REQ_W     = 64,
    parameter int DEPTH     = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    cache_req_arb_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_CORES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ID_W + REQ_W;

    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [ID_W:0]    NUM_CORES_W = (ID_W + 1)'(NUM_CORES);
    localparam logic [ID_W-1:0]  LAST_CORE   = ID_W'(NUM_CORES - 1);

    // Storage holds {id, payload}; read is asynchronous so the head falls through.
    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;

    logic [ID_W-1:0]      cand_idx [NUM_CORES];
    logic [NUM_CORES-1:0] cand_valid;
    logic                 grant_any;
    logic [ID_W-1:0]      grant_idx;
    logic                 push;
    logic                 pop;

    // Scan offset gi maps to core (rr_ptr + gi) mod NUM_CORES; the sum never
    // exceeds 2*NUM_CORES-2, so one conditional subtract is a full modulo.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_scan
            logic [ID_W:0] sum;
            assign sum            = {1'b0, rr_ptr_reg} + (ID_W + 1)'(gi);
            assign cand_idx[gi]   = (sum >= NUM_CORES_W) ? ID_W'(sum - NUM_CORES_W)
                                                         : sum[ID_W-1:0];
            assign cand_valid[gi] = bus.core_valid[cand_idx[gi]];
        end
    endgenerate

    // Lowest scan offset wins. Grant deliberately ignores out_ready, so a full
    // FIFO refuses a push even in a popping cycle; reset forces core_ready low.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
        if (!reset_n || (count_reg == FULL_CNT)) begin
            grant_any = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_ready
            assign bus.core_ready[gi] = grant_any && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign push = grant_any;
    assign pop  = (count_reg != '0) && bus.out_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        rr_ptr_next = rr_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            rr_ptr_next = (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Entries need no reset: count alone decides whether the head is meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= {grant_idx, bus.core_req[grant_idx]};
        end
    end

    assign bus.out_valid = (count_reg != '0);
    assign bus.out_req   = mem[rd_ptr_reg][REQ_W-1:0];
    assign bus.out_id    = mem[rd_ptr_reg][ENT_W-1:REQ_W];
    assign bus.count     = count_reg;

endmodule

// File: tb/tb_cache_req_arb.sv
// Scoreboard bench for cache_req_arb: the driver predicts grants from a
// round-robin reference model and queues expected entries; a monitor checks the head.
`timescale 1ns/1ps
module tb_cache_req_arb;
    localparam int NUM_CORES = 4;
    localparam int REQ_W     = 64;
    localparam int DEPTH     = 4;
    localparam int ID_W      = $clog2(NUM_CORES);

    typedef logic [ID_W+REQ_W-1:0] entry_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cache_req_arb_if #(.NUM_CORES(NUM_CORES), .REQ_W(REQ_W), .DEPTH(DEPTH)) bus ();

    cache_req_arb #(.NUM_CORES(NUM_CORES), .REQ_W(REQ_W), .DEPTH(DEPTH)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: expected FIFO contents and the next core to be scanned first.
    entry_t exp_q[$];
    int     rr_m     = 0;
    bit     in_reset = 1'b1;

    logic [REQ_W-1:0] pay  [NUM_CORES];
    bit               pend [NUM_CORES];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (exp_q.size() >= DEPTH) return -1;
        for (int k = 0; k < NUM_CORES; k++) begin
            int c;
            c = (rr_m + k) % NUM_CORES;
            if (bus.core_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive(input logic [NUM_CORES-1:0] valid, input logic rdy);
        for (int i = 0; i < NUM_CORES; i++) bus.core_req[i] = pay[i];
        bus.core_valid = valid;
        bus.out_ready  = rdy;
    endtask

    // One clock: check the grant mid-cycle, commit the model at the edge, then
    // return 1 ns after the edge so the caller can drive the next cycle.
    task automatic tick(output int g);
        entry_t               item;
        logic [NUM_CORES-1:0] exp_rdy;
        g    = -1;
        item = '0;
        @(negedge clock);
        if (!in_reset) begin
            g       = model_grant();
            exp_rdy = '0;
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                item       = {ID_W'(g), bus.core_req[g]};
            end
            chk("core_ready", bus.core_ready, exp_rdy);
        end
        @(posedge clock);
        if (g >= 0) begin
            exp_q.push_back(item);
            rr_m = (g + 1) % NUM_CORES;
        end
        #1;
    endtask

    // Monitor: head, valid and occupancy compared every cycle; pops at the edge.
    initial begin : monitor
        bit     do_pop;
        entry_t head;
        forever begin
            @(negedge clock);
            do_pop = 1'b0;
            if (!in_reset) begin
                chk("out_valid", bus.out_valid, exp_q.size() != 0);
                chk("count", bus.count, exp_q.size());
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    chk("out_id", bus.out_id, head[ID_W+REQ_W-1:REQ_W]);
                    chk("out_req", bus.out_req, head[REQ_W-1:0]);
                    do_pop = bus.out_ready;
                end
            end
            @(posedge clock);
            if (do_pop && !in_reset) begin
                head = exp_q.pop_front();
                $display("pop id=%0d req=%016h", head[ID_W+REQ_W-1:REQ_W], head[REQ_W-1:0]);
            end
        end
    end

    initial begin : driver
        int g;
        int sent;
        int grants;
        for (int i = 0; i < NUM_CORES; i++) begin
            pay[i]  = '0;
            pend[i] = 1'b0;
        end
        drive('0, 1'b0);

        // Reset state, with all cores requesting so core_ready must be held low.
        @(posedge clock);
        #1;
        drive('1, 1'b1);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_count", bus.count, 0);
        chk("rst_core_ready", bus.core_ready, 4'b0000);
        drive('0, 1'b0);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        in_reset = 1'b0;

        // Single request from core 2.
        pay[2] = 64'hA5;
        drive(4'b0100, 1'b1);
        tick(g);
        drive(4'b0000, 1'b1);
        tick(g);
        tick(g);

        // All cores hold valid: grants rotate, out_id follows one cycle later.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NUM_CORES; i++) pay[i] = {32'h0000_1000 + i, 32'(c)};
            drive(4'b1111, 1'b1);
            tick(g);
        end

        // Full backpressure from cores 0 and 1.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NUM_CORES; i++) pay[i] = {32'h0000_2000 + i, 32'(c)};
            drive(4'b0011, 1'b0);
            tick(g);
        end
        chk("full_count", bus.count, DEPTH);
        chk("full_core_ready", bus.core_ready, 4'b0000);
        drive(4'b0011, 1'b1);
        tick(g);
        for (int c = 0; c < 3; c++) begin
            drive(4'b0011, 1'b0);
            tick(g);
        end
        chk("refill_count", bus.count, DEPTH);

        // Full with pop: core 3 under sustained flow.
        for (int c = 0; c < 8; c++) begin
            pay[3] = {32'h0000_3000, 32'(c)};
            drive(4'b1000, 1'b1);
            tick(g);
        end

        // Drain, then wrap-around ordering from a single core.
        for (int c = 0; c < 6; c++) begin
            drive('0, 1'b1);
            tick(g);
        end
        sent = 0;
        for (int c = 0; c < 200 && sent < 10; c++) begin
            pay[1] = 64'hC0DE_0000_0000_0000 + 64'(sent);
            drive(4'b0010, 1'($urandom_range(0, 1)));
            tick(g);
            if (g == 1) sent++;
        end
        chk("wrap_sent", sent, 10);
        for (int c = 0; c < 12; c++) begin
            drive('0, 1'($urandom_range(0, 1)));
            tick(g);
        end
        for (int c = 0; c < 6; c++) begin
            drive('0, 1'b1);
            tick(g);
        end

        // Build count=3, then reset between edges.
        grants = 0;
        for (int c = 0; c < 20 && grants < 3; c++) begin
            pay[0] = 64'hDEAD_0000_0000_0000 + 64'(c);
            drive(4'b0001, 1'b0);
            tick(g);
            if (g >= 0) grants++;
        end
        chk("pre_reset_count", bus.count, 3);
        pay[1] = 64'h0000_0000_0000_B1B1;
        drive(4'b0010, 1'b0);
        #2;
        reset_n  = 1'b0;
        in_reset = 1'b1;
        exp_q.delete();
        rr_m = 0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_count", bus.count, 0);
        chk("midrst_core_ready", bus.core_ready, 4'b0000);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        in_reset = 1'b0;
        tick(g);
        drive('0, 1'b1);
        tick(g);
        tick(g);

        // Randomized traffic with holding cores and occasional withdrawn requests.
        for (int c = 0; c < 2000; c++) begin
            logic [NUM_CORES-1:0] v;
            int                   bias;
            bias = (c / 250) % 4;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pay[i]  = {$urandom, $urandom};
                end
                v[i] = pend[i];
            end
            drive(v, 1'($urandom_range(0, 3) <= bias));
            tick(g);
            if (g >= 0) pend[g] = 1'b0;
        end

        for (int c = 0; c < 8; c++) begin
            drive('0, 1'b1);
            tick(g);
        end
        chk("final_count", bus.count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
